// File: rtl/ch_aline_storage.sv
// Single-port register-file storage: DEPTH words of DATA_W bits with a
// registered, write-first read port and asynchronous active-low clear.
module ch_aline_storage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic              in_range;
  logic              wr_hit;

  // Only meaningful when DEPTH < 2**ADDR_W; otherwise always true.
  assign in_range = (32'(addr) < 32'(DEPTH));
  assign wr_hit   = wr_en && in_range;

  // Write-first: a same-cycle write bypasses the array into the read register.
  always_comb begin
    data_out_d = '0;
    if (wr_hit) begin
      data_out_d = data_in;
    end else if (in_range) begin
      data_out_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ch_aline_storage.sv
// Directed-plus-random bench for ch_aline_storage against an array model.
module tb_ch_aline_storage;

  logic       clk;
  logic       rst;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic       wr_en;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [32];
  logic [7:0] exp_out;

  ch_aline_storage dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .data_out (data_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    exp_out = 8'h00;
  endtask

  // One clock: drive at negedge, confirm output holds, sample after the edge.
  task automatic step(input logic wr, input logic [4:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    wr_en   = wr;
    addr    = a;
    data_in = d;
    #1;
    check({tag, "_hold"}, data_out, exp_out);
    @(posedge clk);
    #1;
    if (wr) begin
      model_mem[a] = d;
    end
    exp_out = model_mem[a];
    check(tag, data_out, exp_out);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 5'(a), 8'($urandom), tag);
    end
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b1;
    addr    = 5'd0;
    data_in = 8'h1B;
    model_clear();

    // reset held with write requested
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("reset_hold", data_out, 8'h00);
      addr = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    #1;
    check("release_pre_edge", data_out, 8'h00);
    read_all("reset_readback");

    // single write, write-first then persistent
    step(1'b1, 5'd0, 8'h1B, "single_wr");
    check("single_wr_const", data_out, 8'h1B);
    step(1'b0, 5'd0, 8'h00, "single_rd0");
    step(1'b0, 5'd0, 8'hFF, "single_rd1");

    // full array
    for (int a = 0; a < 32; a++) begin
      step(1'b1, 5'(a), 8'(a) ^ 8'hA5, "full_wr");
    end
    read_all("full_rd");
    check("full_rd_31_const", data_out, 8'hBA);

    // isolation
    step(1'b1, 5'd5, 8'hFF, "iso_wr5");
    step(1'b1, 5'd6, 8'h00, "iso_wr6");
    step(1'b0, 5'd5, 8'h00, "iso_rd5");
    check("iso_rd5_const", data_out, 8'hFF);
    step(1'b0, 5'd4, 8'h00, "iso_rd4");
    check("iso_rd4_const", data_out, 8'hA1);

    // write disabled sweep
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 5'($urandom_range(0, 31)), 8'($urandom), "wr_dis");
    end
    read_all("wr_dis_rd");

    // random mix, including back-to-back writes to one address
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), "rand");
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd9, 8'($urandom), "burst_same");
    end
    read_all("rand_rd");

    // async reset mid-run: 3 ns pulse between edges
    for (int a = 0; a < 32; a++) begin
      step(1'b1, 5'(a), 8'(a) ^ 8'hA5, "pre_pulse_wr");
    end
    step(1'b0, 5'd31, 8'h00, "pre_pulse_rd");
    #1;
    rst = 1'b0;
    #1;
    check("pulse_out", data_out, 8'h00);
    #2;
    rst = 1'b1;
    model_clear();
    read_all("post_pulse_rd");

    // reset spanning a write edge discards the write
    step(1'b1, 5'd3, 8'h5A, "pre_span_wr");
    @(negedge clk);
    wr_en   = 1'b1;
    addr    = 5'd3;
    data_in = 8'h77;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("span_out", data_out, 8'h00);
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    model_clear();
    #1;
    check("span_release", data_out, 8'h00);
    step(1'b0, 5'd3, 8'h00, "span_rd3");
    read_all("span_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
